// File: rtl/conv_result_collector_if.sv
// Result-port bundle between the conv engine (write side), the collector and
// the downstream consumer (row stream side).
//   master: conv engine / downstream consumer side (drives writes and out_rdy)
//   slave : conv_result_collector
interface conv_result_collector_if #(
  parameter int LANES     = 24,
  parameter int AW        = 3,
  parameter int RES_WIDTH = 32
);
  logic [LANES*AW-1:0]        result_wraddress;
  logic [LANES*RES_WIDTH-1:0] result_data_in;
  logic [LANES-1:0]           result_wren;
  logic [LANES*RES_WIDTH-1:0] out_data;
  logic [AW-1:0]              out_row;
  logic                       out_val;
  logic                       out_rdy;
  logic                       frame_done;
  logic                       addr_err;
  logic                       ovw_err;

  modport master (
    output result_wraddress, result_data_in, result_wren, out_rdy,
    input  out_data, out_row, out_val, frame_done, addr_err, ovw_err
  );

  modport slave (
    input  result_wraddress, result_data_in, result_wren, out_rdy,
    output out_data, out_row, out_val, frame_done, addr_err, ovw_err
  );
endinterface

// File: rtl/conv_result_collector.sv
// conv_result_collector
//   Collects per-lane (channel x column) row writes from the conv engine into a
//   full result frame, tracks which lanes of each row have arrived, and streams
//   completed rows out strictly in row order, one whole row per val/rdy beat.
//   Writes are never back-pressured; bad addresses and overwrites of lanes that
//   are still pending are flagged with sticky error bits.
//
// Optional feature macro: CONV_RESULT_RELU_EN
//   When defined, each 32-bit lane of out_data is clamped at zero (signed ReLU)
//   as it is loaded into the output register. Stored data is never modified.
module conv_result_collector #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int FILTER_W   = 3,
  parameter int FILTER_H   = 3,
  parameter int RESULT_D   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  conv_result_collector_if.slave  bus
);

  localparam int RES_WIDTH           = DATA_WIDTH * 4;
  localparam int RESULT_W            = IMG_W - FILTER_W + 1;
  localparam int RESULT_H            = IMG_H - FILTER_H + 1;
  localparam int RESULT_H_ADDR_WIDTH = $clog2(RESULT_H);
  localparam int AW                  = RESULT_H_ADDR_WIDTH;
  localparam int LANES               = RESULT_D * RESULT_W;

  localparam logic [AW-1:0] LAST_ROW = AW'(RESULT_H - 1);

  // Drain FSM encoding
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_VALID = 1'b1;

  // ---------------------------------------------------------------------------
  // Write-side decode
  // ---------------------------------------------------------------------------
  logic [AW-1:0]    lane_addr [LANES];
  logic [LANES-1:0] lane_wr_ok;      // enabled and address inside the frame
  logic [LANES-1:0] lane_bad_addr;   // enabled with an address past the last row
  logic [LANES-1:0] lane_ovw;        // enabled onto a lane whose mask bit is set

  // Per-row lane arrival masks and their completion flags
  logic [LANES-1:0]    mask_reg  [RESULT_H];
  logic [LANES-1:0]    mask_next [RESULT_H];
  logic [RESULT_H-1:0] row_full;

  // Drain control
  logic [0:0]    state_reg, state_next;
  logic [AW-1:0] rd_row_reg, rd_row_next;
  logic [AW-1:0] next_row;
  logic [AW-1:0] rd_addr;        // row read into the output register on load
  logic          load;           // capture a row into out_data/out_row
  logic          clr_en;         // handshake: retire row rd_row_reg
  logic [AW-1:0] out_row_reg;
  logic          addr_err_reg;
  logic          ovw_err_reg;

  logic [LANES*RES_WIDTH-1:0] out_data_w;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_dec
    assign lane_addr[gi]     = bus.result_wraddress[gi*AW +: AW];
    assign lane_wr_ok[gi]    = bus.result_wren[gi] && (32'(lane_addr[gi]) < 32'(RESULT_H));
    assign lane_bad_addr[gi] = bus.result_wren[gi] && !(32'(lane_addr[gi]) < 32'(RESULT_H));
  end

  for (genvar gi = 0; gi < RESULT_H; gi++) begin : g_row_full
    assign row_full[gi] = &mask_reg[gi];
  end

  // Flag lanes that land on an already-filled slot, including a slot being
  // retired by this cycle's handshake (the retire wins, so that data is lost).
  always_comb begin
    lane_ovw = '0;
    for (int l = 0; l < LANES; l++) begin
      if (lane_wr_ok[l]) begin
        if (mask_reg[lane_addr[l]][l] || (clr_en && (lane_addr[l] == rd_row_reg))) begin
          lane_ovw[l] = 1'b1;
        end
      end
    end
  end

  // Next mask state: set bits for accepted writes, then clear the retiring row.
  always_comb begin
    for (int r = 0; r < RESULT_H; r++) begin
      mask_next[r] = mask_reg[r];
      for (int l = 0; l < LANES; l++) begin
        if (lane_wr_ok[l] && (lane_addr[l] == AW'(r))) begin
          mask_next[r][l] = 1'b1;
        end
      end
      if (clr_en && (rd_row_reg == AW'(r))) begin
        mask_next[r] = '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drain FSM: present row rd_row once complete; on handshake retire it and
  // either chain straight into the following row or fall back to idle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    rd_row_next = rd_row_reg;
    rd_addr     = rd_row_reg;
    load        = 1'b0;
    clr_en      = 1'b0;
    next_row    = (rd_row_reg == LAST_ROW) ? '0 : rd_row_reg + AW'(1);
    case (state_reg)
      ST_IDLE: begin
        if (row_full[rd_row_reg]) begin
          load       = 1'b1;
          state_next = ST_VALID;
        end
      end
      ST_VALID: begin
        if (bus.out_rdy) begin
          clr_en      = 1'b1;
          rd_row_next = next_row;
          if (row_full[next_row]) begin
            load    = 1'b1;
            rd_addr = next_row;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Control state, output row index and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      rd_row_reg   <= '0;
      out_row_reg  <= '0;
      addr_err_reg <= 1'b0;
      ovw_err_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rd_row_reg <= rd_row_next;
      if (load) begin
        out_row_reg <= rd_addr;
      end
      addr_err_reg <= addr_err_reg | (|lane_bad_addr);
      ovw_err_reg  <= ovw_err_reg | (|lane_ovw);
    end
  end

  // Lane arrival masks; cleared on reset so a fresh frame starts clean.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < RESULT_H; r++) begin
        mask_reg[r] <= '0;
      end
    end else begin
      for (int r = 0; r < RESULT_H; r++) begin
        mask_reg[r] <= mask_next[r];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: one small RAM per lane (one write, one registered read each).
  // The read register doubles as the out_data holding register.
  // ---------------------------------------------------------------------------
  function automatic logic [RES_WIDTH-1:0] out_xform(input logic [RES_WIDTH-1:0] v);
`ifdef CONV_RESULT_RELU_EN
    out_xform = v[RES_WIDTH-1] ? '0 : v;
`else
    out_xform = v;
`endif
  endfunction

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_mem
    logic [RES_WIDTH-1:0] mem [RESULT_H];
    logic [RES_WIDTH-1:0] lane_q_reg;

    // Lane write port; storage is intentionally not reset.
    always_ff @(posedge clk) begin
      if (lane_wr_ok[gi]) begin
        mem[lane_addr[gi]] <= bus.result_data_in[gi*RES_WIDTH +: RES_WIDTH];
      end
    end

    // Registered read of the row being presented; held while out_rdy is low.
    always_ff @(posedge clk) begin
      if (load) begin
        lane_q_reg <= out_xform(mem[rd_addr]);
      end
    end

    assign out_data_w[gi*RES_WIDTH +: RES_WIDTH] = lane_q_reg;
  end

  assign bus.out_data   = out_data_w;
  assign bus.out_row    = out_row_reg;
  assign bus.out_val    = (state_reg == ST_VALID);
  assign bus.frame_done = (state_reg == ST_VALID) && bus.out_rdy && (rd_row_reg == LAST_ROW);
  assign bus.addr_err   = addr_err_reg;
  assign bus.ovw_err    = ovw_err_reg;

endmodule
